// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M multiply/divide unit for the EX stage.
// Divides with a restoring algorithm at one quotient bit per cycle. Multiplies
// with radix-2 shift-add at one bit per cycle, or in a single cycle when the
// MULDIV_FAST_MUL_EN macro is defined. Results carry a one-cycle done pulse,
// and result holds its value until the next done.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [5:0]        r_count;
  logic [2:0]        r_func3;
  logic              r_neg_a;
  logic              r_neg_b;
  // r_mag holds the multiplicand (multiply) or the divisor (divide).
  logic [XLEN-1:0]   r_mag;
  // r_acc is {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_is_div;
  logic              w_signed_a;
  logic              w_signed_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN-1:0]   w_special_val;
  logic              w_res_load;
  logic [XLEN-1:0]   w_res_val;

  // Operand decode for the op presented while IDLE.
  assign w_accept   = (r_state == IDLE) & start & ~kill;
  assign w_is_div   = func3[2];
  assign w_signed_a = w_is_div ? ~func3[0] : (func3[1:0] != 2'b11);
  assign w_signed_b = w_is_div ? ~func3[0] : ~func3[1];
  assign w_neg_a    = w_signed_a & operand_a[XLEN-1];
  assign w_neg_b    = w_signed_b & operand_b[XLEN-1];
  assign w_mag_a    = w_neg_a ? -operand_a : operand_a;
  assign w_mag_b    = w_neg_b ? -operand_b : operand_b;

  // Divide special cases resolve at once. The overflow quotient equals the
  // dividend (the most negative value), so operand_a serves for both cases.
  assign w_div_zero    = (operand_b == '0);
  assign w_div_ovf     = w_signed_a & (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (operand_b == '1);
  assign w_special     = w_is_div & (w_div_zero | w_div_ovf);
  assign w_special_val = func3[1] ? (w_div_zero ? operand_a : '0)
                                  : (w_div_zero ? '1 : operand_a);

  // One shift-add multiply step: add the multiplicand into the upper half
  // when the current multiplier LSB is set, then shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_acc;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, ({XLEN{r_acc[0]}} & r_mag)};
  assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

  // One restoring divide step. The remainder is always below the divisor, so
  // the low XLEN bits of the subtraction are exact when it does not borrow.
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_acc;
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mag});
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_mag;
  assign w_div_acc   = {(w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_div_ge};

  logic [2*XLEN-1:0] w_acc_step;
  assign w_acc_step = r_func3[2] ? w_div_acc : w_mul_acc;

  // Sign correction on the final iteration's accumulator value.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;
  assign w_prod  = (r_neg_a ^ r_neg_b) ? -w_acc_step : w_acc_step;
  assign w_quot  = (r_neg_a ^ r_neg_b) ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
  assign w_rem   = r_neg_a ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];
  assign w_final = r_func3[2] ? (r_func3[1] ? w_rem : w_quot)
                              : ((r_func3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle signed product of the sign-extended operands. Sign-extending
  // to 2*XLEN gives the same low 2*XLEN bits as a 33x33 signed product.
  logic signed [2*XLEN-1:0] w_fast_a;
  logic signed [2*XLEN-1:0] w_fast_b;
  logic signed [2*XLEN-1:0] w_fast_prod;
  logic        [XLEN-1:0]   w_fast_res;
  assign w_fast_a    = {{XLEN{w_neg_a}}, operand_a};
  assign w_fast_b    = {{XLEN{w_neg_b}}, operand_b};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast_res  = (func3[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`endif

  // Next-state, result-load and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_res_load   = 1'b0;
    w_res_val    = w_final;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_div) begin
            if (w_special) begin
              w_state_next = DONE;
              w_res_load   = 1'b1;
              w_res_val    = w_special_val;
            end else begin
              w_state_next = DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            w_state_next = DONE;
            w_res_load   = 1'b1;
            w_res_val    = w_fast_res;
`else
            w_state_next = MUL;
`endif
          end
        end
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (kill) begin
          w_state_next = IDLE;
        end else if (r_count == 6'(XLEN-1)) begin
          w_state_next = DONE;
          w_res_load   = 1'b1;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture, iteration datapath and the held result.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_func3  <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_mag    <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_func3 <= func3;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_mag   <= w_is_div ? w_mag_b : w_mag_a;
        r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        r_count <= '0;
      end else if (busy) begin
        r_acc   <= w_acc_step;
        r_count <= r_count + 6'd1;
      end
      if (w_res_load) begin
        r_result <= w_res_val;
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a vector table for result and latency,
// plus sequences for kill, kill-with-start, mid-op reset and operand changes.
module tb_ex_muldiv_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic        kill;
  logic [2:0]  func3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 32;
`endif

  // kind: 0 multiply, 1 iterative divide, 2 special-case divide
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          kind;
    string       name;
  } vec_t;

  vec_t vecs[20];

  always #5 CLK = ~CLK;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .start     (start),
    .kill      (kill),
    .func3     (func3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, then count busy cycles and the done latency from the accept edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int kind, input string name);
    int lat;
    int bcnt;
    int exp_lat;
    int exp_busy;
    exp_lat  = (kind == 0) ? MUL_LAT : ((kind == 1) ? 33 : 1);
    exp_busy = (kind == 0) ? MUL_BUSY : ((kind == 1) ? 32 : 0);
    @(negedge CLK);
    func3 = f; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge CLK); #1;
    end
    $display("op %-12s a=%h b=%h result=%h latency=%0d busy_cycles=%0d", name, a, b, result, lat, bcnt);
    check({name, " result"}, result, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(bcnt), 32'(exp_busy));
    @(posedge CLK); #1;
    check({name, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0, "MUL"};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 0, "MULHU"};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 0, "MULH"};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 0, "MULHSU"};
    vecs[4]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 0, "MULH min"};
    vecs[5]  = '{3'b010, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0, "MULHSU min"};
    vecs[6]  = '{3'b000, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0, "MUL min"};
    vecs[7]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1, "DIV -7/2"};
    vecs[8]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1, "REM -7/2"};
    vecs[9]  = '{3'b101, 32'd100,        32'd7,        32'd14,       1, "DIVU"};
    vecs[10] = '{3'b111, 32'd100,        32'd7,        32'd2,        1, "REMU"};
    vecs[11] = '{3'b100, 32'd20,         32'hFFFFFFFD, 32'hFFFFFFFA, 1, "DIV 20/-3"};
    vecs[12] = '{3'b110, 32'd20,         32'hFFFFFFFD, 32'd2,        1, "REM 20/-3"};
    vecs[13] = '{3'b100, 32'h80000000,   32'd1,        32'h80000000, 1, "DIV min/1"};
    vecs[14] = '{3'b101, 32'h00001234,   32'd0,        32'hFFFFFFFF, 2, "DIVU by0"};
    vecs[15] = '{3'b110, 32'h00001234,   32'd0,        32'h00001234, 2, "REM by0"};
    vecs[16] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 2, "DIV ovf"};
    vecs[17] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 2, "REM ovf"};
    vecs[18] = '{3'b111, 32'd7,          32'd0,        32'd7,        2, "REMU by0"};
    vecs[19] = '{3'b101, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 1, "DIVU max/1"};

    Reset = 1'b1; start = 1'b0; kill = 1'b0; func3 = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].kind, vecs[i].name);
    end

    // Kill at iteration 10 of a DIV: no done, result keeps the last value (0xFFFFFFFF).
    @(negedge CLK);
    func3 = 3'b100; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
    end
    check("kill busy before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge CLK); #1;
    kill = 1'b0;
    $display("op kill        busy=%0d done=%0d result=%h", busy, done, result);
    check("kill busy after", 32'(busy), 32'd0);
    check("kill done", 32'(done), 32'd0);
    check("kill result held", result, 32'hFFFFFFFF);
    run_op(3'b101, 32'd9, 32'd3, 32'd3, 1, "DIVU 9/3");

    // kill together with start in IDLE: the op must not be accepted.
    @(negedge CLK);
    func3 = 3'b100; operand_a = 32'd50; operand_b = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; kill = 1'b0;
    check("kill+start cycle1", 32'({busy, done}), 32'd0);
    @(posedge CLK); #1;
    $display("op kill+start  busy=%0d done=%0d result=%h", busy, done, result);
    check("kill+start cycle2", 32'({busy, done}), 32'd0);
    check("kill+start result", result, 32'd3);

    // Reset asserted at iteration 20 of a MUL.
    @(negedge CLK);
    func3 = 3'b000; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (20) begin
      @(posedge CLK); #1;
    end
    Reset = 1'b1;
    @(posedge CLK); #1;
    $display("op reset mid   busy=%0d done=%0d result=%h", busy, done, result);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset result", result, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // start held with changing operands mid-op: in-flight result uses the originals.
    @(negedge CLK);
    func3 = 3'b000; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
    @(posedge CLK); #1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        start = 1'b0;
        break;
      end
      if (k == 5) begin
        operand_a = 32'd100;
        operand_b = 32'd100;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    $display("op MUL held    result=%h latency=%0d", result, lat);
    check("held-start result", result, 32'd42);
    check("held-start latency", 32'(lat), 32'(MUL_LAT));
    @(posedge CLK); #1;
    check("held-start no reaccept", 32'({busy, done}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
